hazard_stall_controller: RTL and testbench

- Central hazard controller for the 5-stage pipeline.
- Drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generates EX-stage forwarding selects.
- Sequences multi-cycle data-memory waits, with a timeout that leads to a sticky error state.

---
 rtl/hazard_stall_controller.sv | 119 +++++++++++
 tb/tb_hazard_stall_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline enable/flush/forward control with a memory-wait timeout.
// Optional HAZ_PERF_CNT_EN adds saturating load-use, branch-flush and memory-wait counters.
module hazard_stall_controller #(
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        err,
`ifdef HAZ_PERF_CNT_EN
    output logic [1:0]  state,
    output logic [31:0] lu_stall_cnt,
    output logic [31:0] br_flush_cnt,
    output logic [31:0] mem_wait_cnt
`else
    output logic [1:0]  state
`endif
);
    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] MEM_WAIT = 2'b01;
    localparam logic [1:0] ERROR    = 2'b10;
    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    logic [WAIT_W-1:0] cnt;
    logic lu_hit, frozen, br, lu_st;

    assign lu_hit = ex_mem_read && ex_rd != 5'd0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    // the illegal encoding 2'b11 behaves like ERROR
    assign frozen = (state == RUN) ? (mem_req && !mem_ready) :
                    (state == MEM_WAIT) ? !mem_ready : 1'b1;
    assign br    = rst && !frozen && ex_branch_taken;
    assign lu_st = rst && !frozen && !ex_branch_taken && lu_hit;

    assign pc_en        = rst && !frozen && !lu_st;
    assign if_id_en     = rst && !frozen && !lu_st;
    assign id_ex_en     = rst && !frozen;
    assign ex_mem_en    = rst && !frozen;
    assign if_id_flush  = br;
    assign id_ex_flush  = br || lu_st;
    assign mem_wb_flush = rst && frozen;

    assign fwd_a = !rst ? 2'b00 :
                   (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b10 :
                   (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b01 : 2'b00;
    assign fwd_b = !rst ? 2'b00 :
                   (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b10 :
                   (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b01 : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
            err   <= 1'b0;
        end else if (state == RUN) begin
            if (mem_req && !mem_ready) begin
                state <= MEM_WAIT;
                cnt   <= WAIT_W'(1);
            end
        end else if (state == MEM_WAIT) begin
            if (mem_ready) begin
                state <= RUN;
                cnt   <= '0;
            end else if (cnt == TIMEOUT) begin
                state <= ERROR;
                err   <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            state <= ERROR;
            err   <= 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic mem_stall_cyc;
    assign mem_stall_cyc = rst && frozen && (state == RUN || state == MEM_WAIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lu_stall_cnt <= '0;
            br_flush_cnt <= '0;
            mem_wait_cnt <= '0;
        end else begin
            if (lu_st && lu_stall_cnt != '1)
                lu_stall_cnt <= lu_stall_cnt + 32'd1;
            if (br && br_flush_cnt != '1)
                br_flush_cnt <= br_flush_cnt + 32'd1;
            if (mem_stall_cyc && mem_wait_cnt != '1)
                mem_wait_cnt <= mem_wait_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed and randomized checks against a cycle-level behavioural model.
module tb_hazard_stall_controller;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic mem_reg_write, mem_req, mem_ready, wb_reg_write;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush, err;
    logic [1:0] fwd_a, fwd_b, state;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] lu_stall_cnt, br_flush_cnt, mem_wait_cnt;
`endif
    logic [13:0] obs;
    int total = 0;
    int passed = 0;
    int m_mode = 0;
    int m_waited = 0;
    logic m_err = 1'b0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.WAIT_W(8), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_req(mem_req), .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .err(err),
`ifdef HAZ_PERF_CNT_EN
        .state(state), .lu_stall_cnt(lu_stall_cnt), .br_flush_cnt(br_flush_cnt),
        .mem_wait_cnt(mem_wait_cnt)
`else
        .state(state)
`endif
    );

    assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush,
                  fwd_a, fwd_b, err, state};

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // expected outputs: {enables, flushes, fwd_a, fwd_b, err, state}
    function automatic logic [13:0] exp_out();
        logic [3:0] en;
        logic [2:0] fl;
        logic lu, frz;
        if (!rst) return {12'b0, m_err, 2'(m_mode)};
        frz = (m_mode == 2) || (!mem_ready && (m_mode == 1 || mem_req));
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        en = 4'b1111;
        fl = 3'b000;
        if (frz) begin
            en = 4'b0000;
            fl = 3'b001;
        end else if (ex_branch_taken) begin
            fl = 3'b110;
        end else if (lu) begin
            en = 4'b0011;
            fl = 3'b010;
        end
        return {en, fl, fwd_model(ex_rs1), fwd_model(ex_rs2), m_err, 2'(m_mode)};
    endfunction

    // m_waited counts consecutive stalled cycles; one more than TMO means timeout
    task automatic model_step();
        logic stalled;
        stalled = !mem_ready && (m_mode == 1 || mem_req);
        if (!rst) begin
            m_mode = 0;
            m_waited = 0;
            m_err = 1'b0;
        end else if (m_mode != 2) begin
            if (stalled) begin
                m_waited++;
                m_mode = (m_waited > TMO) ? 2 : 1;
                m_err = (m_waited > TMO);
            end else begin
                m_waited = 0;
                m_mode = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken} = '0;
        {mem_reg_write, mem_req, wb_reg_write} = '0;
        mem_ready = 1'b1;
    endtask

    task automatic rand_inputs();
        id_rs1 = 5'($urandom_range(0, 3));
        id_rs2 = 5'($urandom_range(0, 3));
        ex_rs1 = 5'($urandom_range(0, 3));
        ex_rs2 = 5'($urandom_range(0, 3));
        ex_rd  = 5'($urandom_range(0, 3));
        mem_rd = 5'($urandom_range(0, 3));
        wb_rd  = 5'($urandom_range(0, 3));
        {id_uses_rs1, id_uses_rs2, ex_mem_read, mem_reg_write, wb_reg_write} = 5'($urandom);
        ex_branch_taken = ($urandom_range(0, 3) == 0);
        mem_req = ($urandom_range(0, 2) == 0);
        mem_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            tick();
            total++;
            if (obs !== 14'b0) $display("FAIL reset_outputs: got %b expected %b", obs, 14'b0);
            else passed++;
        end
        rst = 1'b1;
        idle();
        #1;
        total++;
        if ({pc_en, if_id_en, id_ex_en, ex_mem_en} !== 4'b1111)
            $display("FAIL reset_release: enables got %b expected 1111", {pc_en, if_id_en, id_ex_en, ex_mem_en});
        else passed++;
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_mem_read = 1'b1;
        ex_rd = 5'd5;
        id_rs2 = 5'd5;
        id_uses_rs2 = 1'b1;
        #1;
        total++;
        if ({pc_en, if_id_en, id_ex_flush, id_ex_en} !== 4'b0011)
            $display("FAIL load_use_stall: got %b expected 0011", {pc_en, if_id_en, id_ex_flush, id_ex_en});
        else passed++;
        tick();
        ex_rd = 5'd0;
        #1;
        total++;
        if ({pc_en, if_id_en, id_ex_flush} !== 3'b110)
            $display("FAIL load_use_x0: got %b expected 110", {pc_en, if_id_en, id_ex_flush});
        else passed++;
        tick();
    endtask

    task automatic test_branch_over_load_use();
        idle();
        ex_mem_read = 1'b1;
        ex_rd = 5'd5;
        id_rs2 = 5'd5;
        id_uses_rs2 = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        total++;
        if ({if_id_flush, id_ex_flush, pc_en, mem_wb_flush} !== 4'b1110)
            $display("FAIL branch_priority: got %b expected 1110", {if_id_flush, id_ex_flush, pc_en, mem_wb_flush});
        else passed++;
        tick();
    endtask

    task automatic test_forwarding();
        idle();
        ex_rs1 = 5'd7;
        mem_rd = 5'd7;
        wb_rd = 5'd7;
        mem_reg_write = 1'b1;
        wb_reg_write = 1'b1;
        #1;
        total++;
        if (fwd_a !== 2'b10) $display("FAIL fwd_mem: got %b expected 10", fwd_a);
        else passed++;
        mem_reg_write = 1'b0;
        #1;
        total++;
        if (fwd_a !== 2'b01) $display("FAIL fwd_wb: got %b expected 01", fwd_a);
        else passed++;
        mem_reg_write = 1'b1;
        mem_rd = 5'd0;
        wb_rd = 5'd0;
        ex_rs1 = 5'd0;
        #1;
        total++;
        if (fwd_a !== 2'b00) $display("FAIL fwd_x0: got %b expected 00", fwd_a);
        else passed++;
        tick();
    endtask

    task automatic test_mem_wait();
        idle();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_flush, state} !== {5'b00001, (i == 0) ? 2'b00 : 2'b01})
                $display("FAIL mem_freeze_%0d: got %b expected %b", i,
                         {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_flush, state},
                         {5'b00001, (i == 0) ? 2'b00 : 2'b01});
            else passed++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_flush} !== 5'b11110)
            $display("FAIL mem_release: got %b expected 11110", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_flush});
        else passed++;
        tick();
        total++;
        if (state !== 2'b00) $display("FAIL mem_back_to_run: state got %b expected 00", state);
        else passed++;
    endtask

    task automatic test_timeout();
        idle();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 1; i <= TMO + 1; i++) begin
            tick();
            total++;
            if ({err, state} !== ((i <= TMO) ? 3'b001 : 3'b110))
                $display("FAIL timeout_cycle_%0d: err/state got %b expected %b", i, {err, state},
                         (i <= TMO) ? 3'b001 : 3'b110);
            else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            mem_ready = 1'b1;
            #1;
            total++;
            if ({err, state, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_flush} !== 8'b11000001)
                $display("FAIL error_sticky_%0d: got %b expected 11000001", i,
                         {err, state, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_flush});
            else passed++;
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle();
        #1;
        total++;
        if ({err, state, pc_en} !== 4'b0001)
            $display("FAIL error_reset: got %b expected 0001", {err, state, pc_en});
        else passed++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            rand_inputs();
            #1;
            total++;
            if (obs !== exp_out()) $display("FAIL random_%0d: got %b expected %b", i, obs, exp_out());
            else passed++;
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_forwarding();
        test_mem_wait();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
